// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared widths and the write-back queue entry type used by
//               regfile_wb_queue and wb_fifo.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;

    // One pending register-file write: destination register and its value.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rnum;
        logic [DATA_W-1:0]     data;
    } wb_entry_t;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_fifo
// Description : Write-back queue storage. Accepts up to two pushes per edge
//               (push0 is enqueued first and is therefore the older entry),
//               pops at most one entry per edge. Exposes the head entry and
//               an age-ordered view of all slots (index 0 = oldest) so the
//               parent can build forwarding logic.
// Ports       : clock, reset_n        - clock / async active-low reset
//               push0_i, push0_data_i - first (older) push
//               push1_i, push1_data_i - second (younger) push
//               pop_i                 - remove head this edge
//               head_o                - oldest entry
//               count_o               - number of valid entries
//               ent_o / vld_o         - age-ordered entries and valid flags
// Revision    : 1.0 - initial release
// ============================================================================
module wb_fifo
    import mips_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        push0_i,
    input  wb_entry_t                   push0_data_i,
    input  logic                        push1_i,
    input  wb_entry_t                   push1_data_i,
    input  logic                        pop_i,
    output wb_entry_t                   head_o,
    output logic [$clog2(DEPTH):0]      count_o,
    output wb_entry_t                   ent_o [DEPTH],
    output logic [DEPTH-1:0]            vld_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    wb_entry_t        mem_q [DEPTH];

    logic             w_pop;
    logic [PTR_W-1:0] w_slot1;

    // Never pop an empty queue, whatever the caller does.
    assign w_pop   = pop_i && (count_q != '0);
    // The second push lands right behind the first when both are present.
    assign w_slot1 = wr_ptr_q + PTR_W'(push0_i);

    // DEPTH is a power of two, so pointer arithmetic wraps on its own.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push0_i) + PTR_W'(push1_i);
        rd_ptr_d = rd_ptr_q + PTR_W'(w_pop);
        count_d  = count_q + CNT_W'(push0_i) + CNT_W'(push1_i) - CNT_W'(w_pop);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset: validity is carried by count_q.
    always_ff @(posedge clock) begin
        if (push0_i) begin
            mem_q[wr_ptr_q] <= push0_data_i;
        end
        if (push1_i) begin
            mem_q[w_slot1] <= push1_data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    for (genvar i = 0; i < DEPTH; i++) begin : g_age
        logic [PTR_W-1:0] w_idx;
        assign w_idx    = rd_ptr_q + PTR_W'(i);
        assign ent_o[i] = mem_q[w_idx];
        assign vld_o[i] = (CNT_W'(i) < count_q);
    end

endmodule : wb_fifo
`default_nettype wire

// File: rtl/regfile_wb_queue.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_queue
// Description : Register-file write-back queue. Merges ALU and load results
//               into an in-order FIFO drained one entry per cycle into the
//               register file, with optional forwarding of pending values
//               to decode-stage reads.
// Macro       : WB_BYPASS_EN - when defined, lk1/lk2 forwarding is built;
//               otherwise lookup outputs are tied to zero.
// Ports       : clock, reset_n                     - clock / async reset
//               alu_valid/reg/data, alu_ready     - ALU write request
//               mem_valid/reg/data, mem_ready     - load write request
//               rf_we, rf_waddr, rf_wdata         - register-file write
//               lk1/lk2_reg -> lk1/lk2_hit/_data  - forwarding lookups
//               occupancy                         - valid entry count
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_queue
    import mips_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   alu_valid,
    input  logic [REG_ADDR_W-1:0]  alu_reg,
    input  logic [DATA_W-1:0]      alu_data,
    output logic                   alu_ready,
    input  logic                   mem_valid,
    input  logic [REG_ADDR_W-1:0]  mem_reg,
    input  logic [DATA_W-1:0]      mem_data,
    output logic                   mem_ready,
    output logic                   rf_we,
    output logic [REG_ADDR_W-1:0]  rf_waddr,
    output logic [DATA_W-1:0]      rf_wdata,
    input  logic [REG_ADDR_W-1:0]  lk1_reg,
    input  logic [REG_ADDR_W-1:0]  lk2_reg,
    output logic                   lk1_hit,
    output logic                   lk2_hit,
    output logic [DATA_W-1:0]      lk1_data,
    output logic [DATA_W-1:0]      lk2_data,
    output logic [$clog2(DEPTH):0] occupancy
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [CNT_W-1:0] w_free;
    logic             w_mem_push;
    logic             w_alu_push;
    wb_entry_t        w_mem_entry;
    wb_entry_t        w_alu_entry;
    wb_entry_t        w_head;
    wb_entry_t        w_ent [DEPTH];
    logic [DEPTH-1:0] w_vld;

    // Readiness is judged on start-of-cycle space and deliberately ignores
    // the pop happening on the same edge, keeping it off the commit path.
    assign w_free    = CNT_W'(DEPTH) - occupancy;
    assign mem_ready = (w_free != '0);
    assign alu_ready = mem_valid ? (w_free >= CNT_W'(2)) : (w_free != '0);

    // Writes to r0 complete the handshake but are dropped.
    assign w_mem_push  = mem_valid && mem_ready && (mem_reg != '0);
    assign w_alu_push  = alu_valid && alu_ready && (alu_reg != '0);
    assign w_mem_entry = {mem_reg, mem_data};
    assign w_alu_entry = {alu_reg, alu_data};

    // MEM goes into the first slot so it is older than a same-edge ALU write.
    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock        (clock),
        .reset_n      (reset_n),
        .push0_i      (w_mem_push),
        .push0_data_i (w_mem_entry),
        .push1_i      (w_alu_push),
        .push1_data_i (w_alu_entry),
        .pop_i        (rf_we),
        .head_o       (w_head),
        .count_o      (occupancy),
        .ent_o        (w_ent),
        .vld_o        (w_vld)
    );

    // The register file always accepts, so presenting the head is a commit.
    assign rf_we    = (occupancy != '0);
    assign rf_waddr = rf_we ? w_head.rnum : '0;
    assign rf_wdata = rf_we ? w_head.data : '0;

`ifdef WB_BYPASS_EN
    // Walk entries oldest to youngest; the last match wins, giving the
    // youngest pending value for each lookup.
    always_comb begin
        lk1_hit  = 1'b0;
        lk1_data = '0;
        lk2_hit  = 1'b0;
        lk2_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_vld[i] && (lk1_reg != '0) && (w_ent[i].rnum == lk1_reg)) begin
                lk1_hit  = 1'b1;
                lk1_data = w_ent[i].data;
            end
            if (w_vld[i] && (lk2_reg != '0) && (w_ent[i].rnum == lk2_reg)) begin
                lk2_hit  = 1'b1;
                lk2_data = w_ent[i].data;
            end
        end
    end
`else
    assign lk1_hit  = 1'b0;
    assign lk2_hit  = 1'b0;
    assign lk1_data = '0;
    assign lk2_data = '0;

    // Lookup inputs and the age-ordered view have no consumer in this build.
    logic             w_unused;
    logic [DEPTH-1:0] w_unused_ent;
    assign w_unused = ^{lk1_reg, lk2_reg, w_vld, w_unused_ent};
    for (genvar i = 0; i < DEPTH; i++) begin : g_unused
        assign w_unused_ent[i] = ^w_ent[i];
    end
`endif

endmodule : regfile_wb_queue
`default_nettype wire
